// File: rtl/icache_way_fill_dec.sv
// Refill-side way decoder: picks a victim way for an icache refill and drives its write enable.
// Optional: define ICACHE_VICTIM_LFSR_EN to pick all-valid victims from an 8-bit LFSR instead of round-robin.
module icache_way_fill_dec #(
    parameter int N_WAY = 4,
    parameter int WAY_W = $clog2(N_WAY)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             refill_req_i,
    input  logic [N_WAY-1:0] valid_ways_i,
    input  logic             refill_done_i,
    output logic             busy_o,
    output logic             way_vld_o,
    output logic [N_WAY-1:0] way_we_o,
    output logic [WAY_W-1:0] way_idx_o,
    output logic             evict_o
);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        WRITE
    } state_t;

    state_t           state_q;
    logic [N_WAY-1:0] vmask_q;
    logic [N_WAY-1:0] way_we_q;
    logic [WAY_W-1:0] way_idx_q;
    logic             way_vld_q;
    logic             evict_q;

    logic             all_valid;
    logic [WAY_W-1:0] free_idx;
    logic [WAY_W-1:0] victim_d;
    logic [N_WAY-1:0] victim_we_d;

`ifdef ICACHE_VICTIM_LFSR_EN
    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // x^8+x^6+x^5+x^4+1, Fibonacci form shifting towards the MSB.
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
    localparam logic [WAY_W-1:0] PTR_ONE = 1;

    logic [WAY_W-1:0] rr_ptr_q;
`endif

    // Descending scan so the lowest invalid way is the one left standing.
    always_comb begin
        free_idx  = '0;
        all_valid = &vmask_q;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!vmask_q[i]) begin
                free_idx = i[WAY_W-1:0];
            end
        end
    end

    always_comb begin
        victim_we_d = '0;
`ifdef ICACHE_VICTIM_LFSR_EN
        victim_d = all_valid ? lfsr_q[WAY_W-1:0] : free_idx;
`else
        victim_d = all_valid ? rr_ptr_q : free_idx;
`endif
        victim_we_d[victim_d] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            vmask_q   <= '0;
            way_we_q  <= '0;
            way_idx_q <= '0;
            way_vld_q <= 1'b0;
            evict_q   <= 1'b0;
`ifdef ICACHE_VICTIM_LFSR_EN
            lfsr_q    <= 8'h01;
`else
            rr_ptr_q  <= '0;
`endif
        end else if (flush_i) begin
            // Flush aborts the fill but keeps the last index visible.
            state_q   <= IDLE;
            way_we_q  <= '0;
            way_vld_q <= 1'b0;
            evict_q   <= 1'b0;
`ifdef ICACHE_VICTIM_LFSR_EN
            lfsr_q    <= 8'h01;
`else
            rr_ptr_q  <= '0;
`endif
        end else begin
            evict_q <= 1'b0;
`ifdef ICACHE_VICTIM_LFSR_EN
            lfsr_q  <= lfsr_d;
`endif
            case (state_q)
                IDLE: begin
                    if (refill_req_i) begin
                        vmask_q <= valid_ways_i;
                        state_q <= SELECT;
                    end
                end
                SELECT: begin
                    way_idx_q <= victim_d;
                    way_we_q  <= victim_we_d;
                    way_vld_q <= 1'b1;
                    evict_q   <= all_valid;
`ifndef ICACHE_VICTIM_LFSR_EN
                    if (all_valid) begin
                        rr_ptr_q <= rr_ptr_q + PTR_ONE;
                    end
`endif
                    state_q   <= WRITE;
                end
                WRITE: begin
                    if (refill_done_i) begin
                        way_vld_q <= 1'b0;
                        way_we_q  <= '0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = (state_q != IDLE);
    assign way_vld_o = way_vld_q;
    assign way_we_o  = way_we_q;
    assign way_idx_o = way_idx_q;
    assign evict_o   = evict_q;

endmodule

// File: tb/tb_icache_way_fill_dec.sv
// Self-checking bench for icache_way_fill_dec: a transaction-level model checked every cycle,
// plus directed fills with literal expectations and a randomised fill/flush phase.
module tb_icache_way_fill_dec;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flush = 1'b0;
    logic         req = 1'b0;
    logic         done = 1'b0;
    logic [N-1:0] valid = '0;

    logic         busy;
    logic         vld;
    logic [N-1:0] we;
    logic [W-1:0] idx;
    logic         evict;

    int vectors = 0;
    int miscompares = 0;

    // Model: fill age (-1 idle, 0 select cycle, >=1 write cycles), evictions since flush, victim.
    int           mAge = -1;
    logic [N-1:0] mMask = '0;
    int           mEvictions = 0;
    logic [7:0]   mLfsr = 8'h01;
    logic [W-1:0] mIdx = '0;
    bit           mAllV = 1'b0;

    icache_way_fill_dec #(.N_WAY(N), .WAY_W(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .refill_req_i (req),
        .valid_ways_i (valid),
        .refill_done_i(done),
        .busy_o       (busy),
        .way_vld_o    (vld),
        .way_we_o     (we),
        .way_idx_o    (idx),
        .evict_o      (evict)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] lfsrNext(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    always @(posedge clk) begin : model
        logic [7:0] lNow;
        int         victim;
        if (rst) begin
            mAge = -1;
            mEvictions = 0;
            mLfsr = 8'h01;
            mIdx = '0;
        end else if (flush) begin
            mAge = -1;
            mEvictions = 0;
            mLfsr = 8'h01;
        end else begin
            lNow = mLfsr;
            mLfsr = lfsrNext(lNow);
            if (mAge < 0) begin
                if (req) begin
                    mMask = valid;
                    mAge = 0;
                end
            end else if (mAge == 0) begin
                mAllV = (mMask == {N{1'b1}});
                victim = 0;
                if (mAllV) begin
`ifdef ICACHE_VICTIM_LFSR_EN
                    victim = int'(lNow) % N;
`else
                    victim = mEvictions % N;
`endif
                    mEvictions++;
                end else begin
                    for (int i = N - 1; i >= 0; i--) if (!mMask[i]) victim = i;
                end
                mIdx = W'(victim);
                mAge = 1;
            end else if (done) begin
                mAge = -1;
            end else begin
                mAge++;
            end
        end
    end

    task automatic compareModel();
        logic         eBusy, eVld, eEv;
        logic [N-1:0] eWe;
        eBusy = (mAge >= 0);
        eVld  = (mAge >= 1);
        eEv   = (mAge == 1) && mAllV;
        eWe   = eVld ? (N'(1) << mIdx) : '0;
        vectors++;
        if (busy !== eBusy || vld !== eVld || we !== eWe || idx !== mIdx || evict !== eEv) begin
            miscompares++;
            $display("[TB] FAIL model t=%0t got busy=%b vld=%b we=%b idx=%0d ev=%b want busy=%b vld=%b we=%b idx=%0d ev=%b",
                     $time, busy, vld, we, idx, evict, eBusy, eVld, eWe, mIdx, eEv);
        end
        vectors++;
        if (!(we == '0 || $onehot(we)) || (vld && !we[idx])) begin
            miscompares++;
            $display("[TB] FAIL onehot t=%0t got we=%b idx=%0d vld=%b want zero-or-onehot matching idx",
                     $time, we, idx, vld);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compareModel();
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] m, input logic d, input logic f);
        req = r;
        valid = m;
        done = d;
        flush = f;
    endtask

    task automatic checkOutput(input string name, input logic eBusy, input logic eVld,
                               input logic [N-1:0] eWe, input logic [W-1:0] eIdx, input logic eEv);
        vectors++;
        if (busy !== eBusy || vld !== eVld || we !== eWe || idx !== eIdx || evict !== eEv) begin
            miscompares++;
            $display("[TB] FAIL %s got busy=%b vld=%b we=%b idx=%0d ev=%b want busy=%b vld=%b we=%b idx=%0d ev=%b",
                     name, busy, vld, we, idx, evict, eBusy, eVld, eWe, eIdx, eEv);
        end
    endtask

    // Leaves the DUT in its first WRITE cycle.
    task automatic startFill(input logic [N-1:0] m);
        applyStimulus(1'b1, m, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, m, 1'b0, 1'b0);
        tick();
    endtask

    task automatic endFill(input int delay);
        repeat (delay) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : stim
        logic [W-1:0] rrSeq [5];
        logic [N-1:0] m;
        int           r;
        rrSeq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        $display("[TB] start");
        tick();
        tick();
        checkOutput("reset", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        rst = 1'b0;
        tick();

        startFill(4'b0000);
        checkOutput("fill_empty", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
        endFill(0);
        checkOutput("fill_empty_done", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);

        startFill(4'b1011);
        checkOutput("fill_1011", 1'b1, 1'b1, 4'b0100, 2'd2, 1'b0);
        endFill(3);

        for (int k = 0; k < 5; k++) begin
            startFill(4'b1111);
`ifndef ICACHE_VICTIM_LFSR_EN
            checkOutput("rr_wrap", 1'b1, 1'b1, 4'b0001 << rrSeq[k], rrSeq[k], 1'b1);
            tick();
            checkOutput("rr_evict_pulse", 1'b1, 1'b1, 4'b0001 << rrSeq[k], rrSeq[k], 1'b0);
`else
            tick();
`endif
            endFill(0);
        end

        startFill(4'b1111);
`ifndef ICACHE_VICTIM_LFSR_EN
        checkOutput("rr_after_wrap", 1'b1, 1'b1, 4'b0010, 2'd1, 1'b1);
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        checkOutput("flush_write", 1'b0, 1'b0, 4'b0000, 2'd1, 1'b0);
        startFill(4'b1111);
        checkOutput("flush_rr_restart", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
`else
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
        startFill(4'b1111);
`endif
        endFill(2);

        applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
        tick();
        checkOutput("req_flush_idle", 1'b0, 1'b0, 4'b0000, idx, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
        tick();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL req_flush_idle_after got busy=%b want busy=0", busy);
        end

        startFill(4'b0000);
        checkOutput("overlap_fill", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
        applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
        tick();
        done = 1'b0;
        checkOutput("done_req_overlap", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        tick();
        checkOutput("overlap_accept", 1'b1, 1'b0, 4'b0000, 2'd0, 1'b0);
        req = 1'b0;
        tick();
        checkOutput("overlap_write", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b0);
        endFill(1);

        startFill(4'b1111);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("reset_midfill", 1'b0, 1'b0, 4'b0000, 2'd0, 1'b0);
        startFill(4'b1111);
`ifndef ICACHE_VICTIM_LFSR_EN
        checkOutput("reset_rr_restart", 1'b1, 1'b1, 4'b0001, 2'd0, 1'b1);
`endif
        endFill(0);

        for (int n = 0; n < 300; n++) begin
            m = N'($urandom);
            if ($urandom_range(0, 2) == 0) m = '1;
            r = $urandom_range(0, 19);
            applyStimulus(1'b1, m, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, N'($urandom), 1'b0, 1'b0);
            if (r == 0) begin
                flush = 1'b1;
                tick();
                flush = 1'b0;
            end else begin
                tick();
                if (r == 1) begin
                    repeat ($urandom_range(0, 3)) tick();
                    flush = 1'b1;
                    tick();
                    flush = 1'b0;
                end else begin
                    endFill($urandom_range(0, 8));
                end
            end
            repeat ($urandom_range(0, 2)) begin
                done = 1'($urandom);
                tick();
            end
            done = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
